// File: rtl/ps2kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: frame FSM states,
// register offsets and STATUS/CTRL/DATA bit positions.
package ps2kbd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int DATA_VALID = 8;
    localparam int ST_EMPTY   = 8;
    localparam int ST_FULL    = 9;
    localparam int ST_OVR     = 10;
    localparam int ST_PERR    = 11;
    localparam int ST_FERR    = 12;
    localparam int CTRL_IE    = 0;
    localparam int CTRL_EN    = 1;

    localparam int FILT_LEN = 4;

    // Odd parity holds when the data bits plus the parity bit contain an odd number of ones
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/if_wb.sv
// Minimal 32-bit Wishbone classic bundle used on the IO bus.
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack;

    modport slave  (input cyc, stb, we, sel, adr, dat_i, output dat_o, ack);
    modport master (output cyc, stb, we, sel, adr, dat_i, input dat_o, ack);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, clock glitch filter, frame FSM and
// inter-bit timeout. Emits one-cycle byte and error pulses to the host side.
module ps2_frame_rx
    import ps2kbd_pkg::*;
#(
    parameter int CLKFREQ = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       perr_p,
    output logic       ferr_p
);
    localparam int TMO_CYC = CLKFREQ / 10000;
    localparam int TMO_W   = $clog2(TMO_CYC + 1);

    logic                clk_p0, clk_p1;
    logic                dat_p0, dat_p1;
    logic [FILT_LEN-1:0] hist_p2;
    logic                clk_filt;
    logic                strobe;
    logic                timeout;

    rx_state_t        state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_ok_q, par_ok_d;
    logic [TMO_W-1:0] tmo_q;
    logic             vld_d, perr_d, ferr_d;

    // Synchroniser and filter stages; the idle line level is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_p0   <= 1'b1;
            clk_p1   <= 1'b1;
            dat_p0   <= 1'b1;
            dat_p1   <= 1'b1;
            hist_p2  <= '1;
            clk_filt <= 1'b1;
        end else begin
            clk_p0  <= ps2_clk;
            clk_p1  <= clk_p0;
            dat_p0  <= ps2_data;
            dat_p1  <= dat_p0;
            hist_p2 <= {hist_p2[FILT_LEN-2:0], clk_p1};
            if (hist_p2 == '0)
                clk_filt <= 1'b0;
            else if (hist_p2 == '1)
                clk_filt <= 1'b1;
        end
    end

    assign strobe  = clk_filt && (hist_p2 == '0);
    assign timeout = (state_q != IDLE) && !strobe && (tmo_q == TMO_W'(TMO_CYC - 1));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_ok_d  = par_ok_q;
        vld_d     = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        if (!en) begin
            state_d = IDLE;
        end else if (timeout) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
        end else if (strobe) begin
            unique case (state_q)
                IDLE: begin
                    if (!dat_p1) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d   = {dat_p1, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7)
                        state_d = PARITY;
                end
                PARITY: begin
                    par_ok_d = odd_parity_ok({dat_p1, shift_q});
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    perr_d  = !par_ok_q;
                    ferr_d  = !dat_p1;
                    vld_d   = par_ok_q && dat_p1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Frame state, timeout counter and registered event pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            par_ok_q   <= 1'b0;
            tmo_q      <= '0;
            byte_valid <= 1'b0;
            perr_p     <= 1'b0;
            ferr_p     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_ok_q   <= par_ok_d;
            tmo_q      <= (state_q == IDLE || strobe) ? '0 : tmo_q + 1'b1;
            byte_valid <= vld_d;
            perr_p     <= perr_d;
            ferr_p     <= ferr_d;
        end
    end

    assign byte_data = shift_q;

endmodule

// File: rtl/ps2kbd_rx.sv
// Wishbone-slave PS/2 keyboard receiver: frame receiver, byte FIFO,
// DATA/STATUS/CTRL register window and level interrupt.
module ps2kbd_rx
    import ps2kbd_pkg::*;
#(
    parameter int CLKFREQ    = 10000000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    if_wb.slave  bus,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic interrupt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic          byte_valid, perr_p, ferr_p;
    logic [7:0]    byte_data;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [8:0]    count;
    logic          empty, full;
    logic          ovr, perr, ferr, ie, en;
    logic          ack_q, irq_q;
    logic [31:0]   dat_q, rd_data;
    logic [1:0]    reg_sel;
    logic          access, pop, push_ok, ovr_set, st_wr, ctrl_wr;
    logic          unused_bus;

    ps2_frame_rx #(.CLKFREQ(CLKFREQ)) u_frame (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .en        (en),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .perr_p    (perr_p),
        .ferr_p    (ferr_p)
    );

    assign reg_sel = bus.adr[3:2];
    assign access  = bus.cyc && bus.stb && !ack_q;
    assign empty   = (count == 9'd0);
    assign full    = (count == 9'(FIFO_DEPTH));
    assign pop     = access && !bus.we && (reg_sel == REG_DATA) && !empty;
    assign push_ok = byte_valid && (!full || pop);
    assign ovr_set = byte_valid && full && !pop;
    assign st_wr   = access && bus.we && (reg_sel == REG_STATUS);
    assign ctrl_wr = access && bus.we && (reg_sel == REG_CTRL);

    // Byte lanes, upper address bits and write data outside the flag fields carry no meaning here
    assign unused_bus = ^{bus.sel, bus.adr[31:4], bus.adr[1:0], bus.dat_i[31:13], bus.dat_i[9:2]};

    always_ff @(posedge clk_i) begin
        if (push_ok)
            mem[wr_ptr] <= byte_data;
    end

    always_comb begin
        rd_data = '0;
        unique case (reg_sel)
            REG_DATA: begin
                if (!empty) begin
                    rd_data[7:0]       = mem[rd_ptr];
                    rd_data[DATA_VALID] = 1'b1;
                end
            end
            REG_STATUS: begin
                rd_data[7:0]     = count[7:0];
                rd_data[ST_EMPTY] = empty;
                rd_data[ST_FULL]  = full;
                rd_data[ST_OVR]   = ovr;
                rd_data[ST_PERR]  = perr;
                rd_data[ST_FERR]  = ferr;
            end
            REG_CTRL: begin
                rd_data[CTRL_IE] = ie;
                rd_data[CTRL_EN] = en;
            end
            default: rd_data = '0;
        endcase
    end

    // FIFO pointers, sticky flags (a set beats a same-cycle clear), control and bus response
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 9'd0;
            ovr    <= 1'b0;
            perr   <= 1'b0;
            ferr   <= 1'b0;
            ie     <= 1'b0;
            en     <= 1'b1;
            ack_q  <= 1'b0;
            dat_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop})
                2'b10:   count <= count + 9'd1;
                2'b01:   count <= count - 9'd1;
                default: count <= count;
            endcase
            ovr  <= ovr_set || (ovr  && !(st_wr && bus.dat_i[ST_OVR]));
            perr <= perr_p  || (perr && !(st_wr && bus.dat_i[ST_PERR]));
            ferr <= ferr_p  || (ferr && !(st_wr && bus.dat_i[ST_FERR]));
            if (ctrl_wr) begin
                ie <= bus.dat_i[CTRL_IE];
                en <= bus.dat_i[CTRL_EN];
            end
            ack_q <= access;
            dat_q <= access ? rd_data : '0;
            irq_q <= ie && !empty;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.dat_o = dat_q;
    assign interrupt = irq_q;

endmodule

// File: tb/tb_ps2kbd_rx.sv
// Self-checking bench for ps2kbd_rx: randomized PS/2 frames against a queue-based
// model of the FIFO and sticky error flags, read back through the Wishbone window.
module tb_ps2kbd_rx;
    localparam int CLKF  = 1000000;
    localparam int DEPTH = 16;
    localparam int HALF  = 40;
    localparam int TMO   = CLKF / 10000;
    localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2, A_RSVD = 2'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic irq;

    if_wb wb();

    ps2kbd_rx #(.CLKFREQ(CLKF), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .bus      (wb.slave),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .interrupt(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    bit m_ovr = 1'b0, m_perr = 1'b0, m_ferr = 1'b0;

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'(exp_q.size());
        if (exp_q.size() == 0)     s = s | 32'h100;
        if (exp_q.size() == DEPTH) s = s | 32'h200;
        if (m_ovr)  s = s | 32'h400;
        if (m_perr) s = s | 32'h800;
        if (m_ferr) s = s | 32'h1000;
        return s;
    endfunction

    function automatic logic [31:0] model_pop();
        if (exp_q.size() == 0) return 32'h0;
        return 32'h100 | 32'(exp_q.pop_front());
    endfunction

    task automatic model_frame(input logic [7:0] b, input bit good_par);
        if (!good_par)                m_perr = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else                           m_ovr = 1'b1;
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] b, input bit good_par);
        logic p;
        p = ~^b;
        if (!good_par) p = ~p;
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic ps2_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (4) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit good_par);
        ps2_bits(mkframe(b, good_par), 11);
        model_frame(b, good_par);
    endtask

    task automatic wb_access(input logic [1:0] r, input bit we, input logic [31:0] wd,
                             output logic [31:0] rd);
        int n;
        @(negedge clk);
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we; wb.sel = 4'hF;
        wb.adr = {28'd0, r, 2'b00}; wb.dat_i = wd;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!wb.ack && n < 8);
        checks++;
        if (!wb.ack) begin
            errors++;
            $display("FAIL wb_ack: no ack after %0d cycles, expected ack within 1", n);
        end
        rd = wb.dat_o;
        @(negedge clk);
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] r, output logic [31:0] d);
        wb_access(r, 1'b0, 32'h0, d);
    endtask

    task automatic wb_write(input logic [1:0] r, input logic [31:0] v);
        logic [31:0] dummy;
        wb_access(r, 1'b1, v, dummy);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        checks++;
        if ({irq, wb.ack, wb.dat_o} !== 34'h0) begin
            errors++;
            $display("FAIL reset_outputs: irq/ack/dat_o=%h expected 0", {irq, wb.ack, wb.dat_o});
        end
        @(negedge clk); rst_n = 1'b1;
        wb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h100) begin errors++; $display("FAIL reset_status: got %h expected %h", d, 32'h100); end
        wb_read(A_CTRL, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL reset_ctrl: got %h expected %h", d, 32'h2); end
        wb_read(A_DATA, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", d); end
        wb_write(A_RSVD, 32'hFFFF_FFFF);
        wb_read(A_RSVD, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rsvd_reg: got %h expected 0", d); end
    endtask

    task automatic test_single();
        logic [31:0] d, e;
        send(8'h1C, 1'b1);
        wb_read(A_STATUS, d);
        checks++;
        if (d !== model_status()) begin errors++; $display("FAIL single_status: got %h expected %h", d, model_status()); end
        wb_write(A_DATA, 32'h55);
        wb_read(A_DATA, d);
        e = model_pop();
        checks++;
        if (d !== e) begin errors++; $display("FAIL single_data: got %h expected %h", d, e); end
        wb_read(A_DATA, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL empty_data: got %h expected 0", d); end
        wb_read(A_STATUS, d);
        checks++;
        if (d !== model_status()) begin errors++; $display("FAIL single_drained: got %h expected %h", d, model_status()); end
    endtask

    task automatic test_parity();
        logic [31:0] d;
        send(8'hF0, 1'b0);
        wb_read(A_STATUS, d);
        checks++;
        if (d !== model_status()) begin errors++; $display("FAIL parity_status: got %h expected %h", d, model_status()); end
        wb_write(A_STATUS, 32'h800);
        m_perr = 1'b0;
        wb_read(A_STATUS, d);
        checks++;
        if (d !== model_status()) begin errors++; $display("FAIL parity_clear: got %h expected %h", d, model_status()); end
    endtask

    task automatic test_timeout();
        logic [31:0] d, e;
        ps2_bits(mkframe(8'h3C, 1'b1), 5);
        repeat (TMO + 50) @(negedge clk);
        m_ferr = 1'b1;
        wb_read(A_STATUS, d);
        checks++;
        if (d !== model_status()) begin errors++; $display("FAIL timeout_ferr: got %h expected %h", d, model_status()); end
        wb_write(A_STATUS, 32'h1000);
        m_ferr = 1'b0;
        send(8'h5A, 1'b1);
        wb_read(A_DATA, d);
        e = model_pop();
        checks++;
        if (d !== e) begin errors++; $display("FAIL after_timeout_data: got %h expected %h", d, e); end
        wb_read(A_STATUS, d);
        checks++;
        if (d !== model_status()) begin errors++; $display("FAIL after_timeout_status: got %h expected %h", d, model_status()); end
    endtask

    task automatic test_disable();
        logic [31:0] d, e;
        wb_write(A_CTRL, 32'h0);
        wb_read(A_CTRL, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL ctrl_write: got %h expected 0", d); end
        ps2_bits(mkframe(8'($urandom), 1'b1), 11);
        wb_read(A_STATUS, d);
        checks++;
        if (d !== model_status()) begin errors++; $display("FAIL disabled_rx: got %h expected %h", d, model_status()); end
        wb_write(A_CTRL, 32'h2);
        ps2_bits(mkframe(8'hA5, 1'b1), 4);
        wb_write(A_CTRL, 32'h0);
        wb_write(A_CTRL, 32'h2);
        repeat (TMO + 50) @(negedge clk);
        wb_read(A_STATUS, d);
        checks++;
        if (d !== model_status()) begin errors++; $display("FAIL abort_silent: got %h expected %h", d, model_status()); end
        send(8'h29, 1'b1);
        wb_read(A_DATA, d);
        e = model_pop();
        checks++;
        if (d !== e) begin errors++; $display("FAIL after_abort_data: got %h expected %h", d, e); end
    endtask

    task automatic test_overflow();
        logic [31:0] d, e;
        for (int i = 0; i < DEPTH + 1; i++)
            send(8'($urandom), 1'b1);
        wb_read(A_STATUS, d);
        checks++;
        if (d !== model_status()) begin errors++; $display("FAIL overflow_status: got %h expected %h", d, model_status()); end
        for (int i = 0; i < DEPTH; i++) begin
            wb_read(A_DATA, d);
            e = model_pop();
            checks++;
            if (d !== e) begin errors++; $display("FAIL overflow_data[%0d]: got %h expected %h", i, d, e); end
        end
        wb_write(A_STATUS, 32'h400);
        m_ovr = 1'b0;
        wb_read(A_STATUS, d);
        checks++;
        if (d !== model_status()) begin errors++; $display("FAIL ovr_clear: got %h expected %h", d, model_status()); end
    endtask

    task automatic test_irq();
        logic [31:0] d, e;
        logic [10:0] f;
        int n;
        wb_write(A_CTRL, 32'h3);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b expected 0", irq); end
        f = mkframe(8'h76, 1'b1);
        ps2_bits(f, 10);
        @(negedge clk); ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        n = 0;
        while (irq !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n < 6 || n > 10) begin errors++; $display("FAIL irq_latency: got %0d cycles expected 6..10", n); end
        model_frame(8'h76, 1'b1);
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        wb_read(A_DATA, d);
        e = model_pop();
        checks++;
        if (d !== e) begin errors++; $display("FAIL irq_data: got %h expected %h", d, e); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_on_ack: got %b expected 1", irq); end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
        wb_write(A_CTRL, 32'h2);
    endtask

    task automatic test_glitch();
        logic [31:0] d, e;
        @(negedge clk); ps2_data = 1'b0; ps2_clk = 1'b0;
        @(negedge clk); ps2_clk = 1'b1;
        repeat (3) @(negedge clk); ps2_data = 1'b1;
        repeat (TMO + 50) @(negedge clk);
        wb_read(A_STATUS, d);
        checks++;
        if (d !== model_status()) begin errors++; $display("FAIL glitch_status: got %h expected %h", d, model_status()); end
        send(8'h81, 1'b1);
        wb_read(A_DATA, d);
        e = model_pop();
        checks++;
        if (d !== e) begin errors++; $display("FAIL glitch_then_data: got %h expected %h", d, e); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, e;
        int n;
        for (int i = 0; i < 8; i++)
            send(8'($urandom), $urandom_range(0, 3) != 0);
        wb_read(A_STATUS, d);
        checks++;
        if (d !== model_status()) begin errors++; $display("FAIL b2b_status: got %h expected %h", d, model_status()); end
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            wb_read(A_DATA, d);
            e = model_pop();
            checks++;
            if (d !== e) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, d, e); end
        end
        wb_write(A_STATUS, 32'h1C00);
        m_perr = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
        wb_read(A_STATUS, d);
        checks++;
        if (d !== model_status()) begin errors++; $display("FAIL b2b_clear: got %h expected %h", d, model_status()); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d, e;
        wb_write(A_CTRL, 32'h3);
        send(8'h3E, 1'b0);
        send(8'h12, 1'b1);
        repeat (4) @(negedge clk);
        ps2_bits(mkframe(8'h99, 1'b1), 5);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({irq, wb.ack, wb.dat_o} !== 34'h0) begin
            errors++;
            $display("FAIL midframe_reset_outputs: irq/ack/dat_o=%h expected 0", {irq, wb.ack, wb.dat_o});
        end
        exp_q.delete();
        m_ovr = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wb_read(A_STATUS, d);
        checks++;
        if (d !== model_status()) begin errors++; $display("FAIL midframe_reset_status: got %h expected %h", d, model_status()); end
        wb_read(A_CTRL, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL midframe_reset_ctrl: got %h expected %h", d, 32'h2); end
        send(8'hE7, 1'b1);
        wb_read(A_DATA, d);
        e = model_pop();
        checks++;
        if (d !== e) begin errors++; $display("FAIL post_reset_data: got %h expected %h", d, e); end
    endtask

    initial begin
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.sel = 4'h0;
        wb.adr = 32'h0; wb.dat_i = 32'h0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        test_parity();
        test_timeout();
        test_disable();
        test_overflow();
        test_irq();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
